// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//   Watches a multiplexed 7-segment display bus (segments + anodes, both
//   active-low and asynchronous to clk) and recovers the BCD value shown on
//   each digit. A {anode, pattern} pair must be seen unchanged for
//   STABLE_CYCLES consecutive synchronized samples before it is committed
//   to that digit, which filters out scan transitions and ghosting.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg_n[6:0]   observed segments {a,b,c,d,e,f,g}, active-low
//   an_n[N-1:0]  observed anode enables, active-low, one-hot-low expected
//   digits       recovered BCD, digit i in [4i+3:4i] (4'hF when not a numeral)
//   digit_valid  digit i holds a numeral 0-9
//   digit_blank  digit i last committed the all-off pattern
//   update       one-cycle pulse per commit
//   update_idx   digit index of the commit (valid while update=1)
//   bad_pattern  one-cycle pulse with update when the pattern is unknown
//   multi_anode  one-cycle pulse per sample with two or more anodes low
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    update,
  output logic [2:0]              update_idx,
  output logic                    bad_pattern,
  output logic                    multi_anode
);

  localparam logic [7:0]            RUN_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0]            RUN_PRE = 8'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE  = NUM_DIGITS'(1);

  logic [6:0]              r_seg_s1, r_seg_s2, r_prev_seg;
  logic [NUM_DIGITS-1:0]   r_an_s1, r_an_s2, r_prev_an;
  logic [7:0]              r_run;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid, r_blank;
  logic                    r_update, r_bad, r_multi;
  logic [2:0]              r_idx;

  logic [NUM_DIGITS-1:0]   w_low;
  logic                    w_any, w_active, w_multi, w_same, w_commit;
  logic [2:0]              w_idx;
  logic [3:0]              w_val;
  logic                    w_is_num, w_is_blank;

  // Sample classification on the synchronized anodes
  assign w_low    = ~r_an_s2;
  assign w_any    = |w_low;
  assign w_active = w_any && ((w_low & (w_low - AN_ONE)) == '0);
  assign w_multi  = w_any && !w_active;
  assign w_same   = (r_an_s2 == r_prev_an) && (r_seg_s2 == r_prev_seg);

  // Commit exactly on the STABLE_CYCLES-1 -> STABLE_CYCLES step; once the
  // counter saturates the condition can no longer be met for this run.
  assign w_commit = w_active && w_same && (r_run == RUN_PRE);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_low[i]) w_idx = 3'(i);
    end
  end

  always_comb begin
    w_val      = 4'hF;
    w_is_num   = 1'b1;
    w_is_blank = 1'b0;
    case (r_seg_s2)
      7'b0000001: w_val = 4'd0;
      7'b1001111: w_val = 4'd1;
      7'b0010010: w_val = 4'd2;
      7'b0000110: w_val = 4'd3;
      7'b1001100: w_val = 4'd4;
      7'b0100100: w_val = 4'd5;
      7'b0100000: w_val = 4'd6;
      7'b0001111: w_val = 4'd7;
      7'b0000000: w_val = 4'd8;
      7'b0000100: w_val = 4'd9;
      7'b1111111: begin
        w_is_num   = 1'b0;
        w_is_blank = 1'b1;
      end
      default:    w_is_num = 1'b0;
    endcase
  end

  // Two-flop synchronizers, previous-pair register and run counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1   <= '0;
      r_seg_s2   <= '0;
      r_an_s1    <= '0;
      r_an_s2    <= '0;
      r_prev_seg <= '0;
      r_prev_an  <= '0;
      r_run      <= '0;
    end else begin
      r_seg_s1   <= seg_n;
      r_seg_s2   <= r_seg_s1;
      r_an_s1    <= an_n;
      r_an_s2    <= r_an_s1;
      r_prev_seg <= r_seg_s2;
      r_prev_an  <= r_an_s2;
      if (!w_active)
        r_run <= '0;
      else if (!w_same)
        r_run <= 8'd1;
      else if (r_run != RUN_MAX)
        r_run <= r_run + 8'd1;
    end
  end

  // Digit store and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '1;
      r_valid  <= '0;
      r_blank  <= '0;
      r_update <= 1'b0;
      r_idx    <= '0;
      r_bad    <= 1'b0;
      r_multi  <= 1'b0;
    end else begin
      r_update <= w_commit;
      r_bad    <= w_commit && !w_is_num && !w_is_blank;
      r_multi  <= w_multi;
      if (w_commit) r_idx <= w_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_commit && (w_idx == 3'(i))) begin
          r_digits[4*i +: 4] <= w_val;
          r_valid[i]         <= w_is_num;
          r_blank[i]         <= w_is_blank;
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign digit_blank = r_blank;
  assign update      = r_update;
  assign update_idx  = r_idx;
  assign bad_pattern = r_bad;
  assign multi_anode = r_multi;

endmodule
